// File: rtl/spi_byte_shifter.sv
// SPI mode-0 byte shifter: one byte per handshake, MSB first, with chip-select hold/gap sequencing.
// Optional SPI_BYTE_SHIFTER_LOOPBACK_EN adds input lpbk to sample s_mosi instead of s_miso.
module spi_byte_shifter #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic       p_clk,
  input  logic       p_reset_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       s_clk,
  output logic       s_mosi,
  input  logic       s_miso,
`ifdef SPI_BYTE_SHIFTER_LOOPBACK_EN
  input  logic       lpbk,
`endif
  output logic       s_css,
  output logic       busy
);

  localparam logic [7:0] DivM1 = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {StDesel, StIdle, StSetup, StShift, StGap, StHold} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  edge_q, edge_d;
  logic        sclk_q, sclk_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        last_q, last_d;
  logic        hs, tick, sample;

  assign tx_ready = (state_q == StIdle) || (state_q == StGap);
  assign busy     = (state_q != StIdle);
  assign s_css    = (state_q == StDesel) || (state_q == StIdle);
  // Bit on the wire is always the top of the shift register; forced low while deselected.
  assign s_mosi   = !s_css && tx_sh_q[7];
  assign s_clk    = sclk_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign hs       = tx_valid && tx_ready;
  assign tick     = (cnt_q == DivM1);

`ifdef SPI_BYTE_SHIFTER_LOOPBACK_EN
  assign sample = lpbk ? s_mosi : s_miso;
`else
  assign sample = s_miso;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    edge_d     = edge_q;
    sclk_d     = sclk_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    last_d     = last_q;
    unique case (state_q)
      StDesel: begin
        if (tick) state_d = StIdle;
        else      cnt_d   = cnt_q + 8'd1;
      end
      StIdle, StGap: begin
        if (hs) begin
          state_d = StSetup;
          tx_sh_d = tx_data;
          last_d  = tx_last;
        end
      end
      StSetup: begin
        if (tick) begin
          state_d = StShift;
          sclk_d  = 1'b1;
          edge_d  = 4'd1;
          rx_sh_d = {rx_sh_q[6:0], sample};
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StShift: begin
        if (!tick) begin
          cnt_d = cnt_q + 8'd1;
        end else if (!sclk_q) begin
          sclk_d  = 1'b1;
          edge_d  = edge_q + 4'd1;
          rx_sh_d = {rx_sh_q[6:0], sample};
        end else if (edge_q == 4'd15) begin
          // Fall 8: byte complete, bit0 stays on s_mosi.
          sclk_d     = 1'b0;
          edge_d     = 4'd0;
          rx_data_d  = rx_sh_q;
          rx_valid_d = 1'b1;
          state_d    = last_q ? StHold : StGap;
        end else begin
          sclk_d  = 1'b0;
          edge_d  = edge_q + 4'd1;
          tx_sh_d = {tx_sh_q[6:0], 1'b0};
        end
      end
      StHold: begin
        if (tick) state_d = StDesel;
        else      cnt_d   = cnt_q + 8'd1;
      end
      default: state_d = StDesel;
    endcase
  end

  always_ff @(posedge p_clk or negedge p_reset_n) begin
    if (!p_reset_n) begin
      state_q    <= StDesel;
      cnt_q      <= '0;
      edge_q     <= '0;
      sclk_q     <= 1'b0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      edge_q     <= edge_d;
      sclk_q     <= sclk_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      last_q     <= last_d;
    end
  end

endmodule

// File: tb/tb_spi_byte_shifter.sv
// Directed bench for spi_byte_shifter: CLK_DIV=2 instance plus a CLK_DIV=1 instance.
module tb_spi_byte_shifter;

  logic p_clk = 1'b0;
  logic p_reset_n = 1'b0;
  always #5 p_clk = ~p_clk;

  logic       tx_valid = 1'b0, tx_last = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, rx_valid, s_clk, s_mosi, s_miso, s_css, busy;
  logic [7:0] rx_data;

  logic       tx_valid1 = 1'b0, tx_last1 = 1'b0;
  logic [7:0] tx_data1 = 8'h00;
  logic       tx_ready1, rx_valid1, s_clk1, s_mosi1, s_miso1, s_css1, busy1;
  logic [7:0] rx_data1;
`ifdef SPI_BYTE_SHIFTER_LOOPBACK_EN
  logic       lpbk1 = 1'b0;
`endif

  spi_byte_shifter #(.CLK_DIV(2)) dut (
    .p_clk(p_clk), .p_reset_n(p_reset_n), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_last(tx_last), .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_data(rx_data),
    .s_clk(s_clk), .s_mosi(s_mosi), .s_miso(s_miso),
`ifdef SPI_BYTE_SHIFTER_LOOPBACK_EN
    .lpbk(1'b0),
`endif
    .s_css(s_css), .busy(busy)
  );

  spi_byte_shifter #(.CLK_DIV(1)) dut1 (
    .p_clk(p_clk), .p_reset_n(p_reset_n), .tx_valid(tx_valid1), .tx_data(tx_data1),
    .tx_last(tx_last1), .tx_ready(tx_ready1), .rx_valid(rx_valid1), .rx_data(rx_data1),
    .s_clk(s_clk1), .s_mosi(s_mosi1), .s_miso(s_miso1),
`ifdef SPI_BYTE_SHIFTER_LOOPBACK_EN
    .lpbk(lpbk1),
`endif
    .s_css(s_css1), .busy(busy1)
  );

  // Flash models: reload while deselected, shift out on each observed s_clk fall.
  logic [7:0] flash_byte = 8'h00, fsh;
  logic [7:0] flash_byte1 = 8'h00, fsh1;
  logic       prev_sclk = 1'b0, prev_sclk1 = 1'b0;
  always @(negedge p_clk) begin
    if (s_css) fsh <= flash_byte;
    else if (prev_sclk && !s_clk) fsh <= {fsh[6:0], 1'b0};
    prev_sclk <= s_clk;
  end
  always @(negedge p_clk) begin
    if (s_css1) fsh1 <= flash_byte1;
    else if (prev_sclk1 && !s_clk1) fsh1 <= {fsh1[6:0], 1'b0};
    prev_sclk1 <= s_clk1;
  end
  assign s_miso  = fsh[7];
  assign s_miso1 = fsh1[7];

  int n_checks = 0;
  int n_fail = 0;

  int         cyc, rises, rxv_n, rxv_cyc, css_hi, css_first;
  logic [7:0] mosi_cap;
  logic       prev_clk;

  task automatic mon_clear();
    cyc = 0; rises = 0; rxv_n = 0; rxv_cyc = 0; css_hi = 0; css_first = 0;
    mosi_cap = 8'h00; prev_clk = s_clk;
  endtask

  task automatic tick();
    @(posedge p_clk); #1;
    cyc++;
    if (s_clk && !prev_clk) begin
      rises++;
      mosi_cap = {mosi_cap[6:0], s_mosi};
    end
    prev_clk = s_clk;
    if (rx_valid) begin
      rxv_n++;
      rxv_cyc = cyc;
    end
    if (s_css) begin
      css_hi++;
      if (css_first == 0) css_first = cyc;
    end
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    tx_valid = 1'b1; tx_data = d; tx_last = last;
    @(posedge p_clk); #1;
    tx_valid = 1'b0;
    mon_clear();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(tx_ready && !busy) && n < 60) begin
      tick();
      n++;
    end
    n_checks++;
    if (!(tx_ready && !busy)) begin
      n_fail++;
      $display("FAIL wait_idle: tx_ready=%b busy=%b, required idle within 60 cycles",
               tx_ready, busy);
    end
  endtask

  task automatic test_reset();
    int n = 0;
    repeat (2) @(posedge p_clk);
    #1;
    n_checks++; if (s_css !== 1'b1) begin n_fail++; $display("FAIL rst_css: %b want 1", s_css); end
    n_checks++; if (s_clk !== 1'b0) begin n_fail++; $display("FAIL rst_sclk: %b want 0", s_clk); end
    n_checks++; if (s_mosi !== 1'b0) begin n_fail++; $display("FAIL rst_mosi: %b want 0", s_mosi); end
    n_checks++;
    if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rxv: %b want 0", rx_valid); end
    n_checks++;
    if (rx_data !== 8'h00) begin n_fail++; $display("FAIL rst_rxd: %h want 00", rx_data); end
    n_checks++;
    if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL rst_rdy: %b want 0", tx_ready); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_busy: %b want 1", busy); end
    p_reset_n = 1'b1;
    mon_clear();
    while (!tx_ready && n < 10) begin tick(); n++; end
    n_checks++;
    if (!(tx_ready === 1'b1 && n == 2)) begin
      n_fail++; $display("FAIL rst_desel_time: ready=%b after %0d cycles, want 1 after 2", tx_ready, n);
    end
  endtask

  task automatic test_a5_last();
    flash_byte = 8'hFF;
    send(8'hA5, 1'b1);
    n_checks++;
    if (s_css !== 1'b0 || s_mosi !== 1'b1 || s_clk !== 1'b0 || tx_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL a5_setup: css=%b mosi=%b sclk=%b rdy=%b want 0 1 0 0",
               s_css, s_mosi, s_clk, tx_ready);
    end
    repeat (40) tick();
    n_checks++;
    if (mosi_cap !== 8'hA5) begin n_fail++; $display("FAIL a5_mosi: %h want a5", mosi_cap); end
    n_checks++; if (rises != 8) begin n_fail++; $display("FAIL a5_rises: %0d want 8", rises); end
    n_checks++;
    if (rx_data !== 8'hFF) begin n_fail++; $display("FAIL a5_rxd: %h want ff", rx_data); end
    n_checks++;
    if (rxv_n != 1 || rxv_cyc != 32) begin
      n_fail++; $display("FAIL a5_rxv: %0d pulses at %0d want 1 at 32", rxv_n, rxv_cyc);
    end
    n_checks++;
    if (css_first != 34) begin n_fail++; $display("FAIL a5_css_hold: %0d want 34", css_first); end
    n_checks++;
    if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL a5_ready: %b want 1", tx_ready); end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    flash_byte = 8'h00;
    send(8'h03, 1'b0);
    while (!tx_ready && n < 40) begin tick(); n++; end
    n_checks++;
    if (cyc != 32 || tx_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_gap: ready=%b at %0d want 1 at 32", tx_ready, cyc);
    end
    tx_valid = 1'b1; tx_data = 8'h00; tx_last = 1'b1;
    tick();
    tx_valid = 1'b0;
    n_checks++;
    if (mosi_cap !== 8'h03) begin n_fail++; $display("FAIL b2b_mosi: %h want 03", mosi_cap); end
    repeat (40) tick();
    n_checks++;
    if (css_first != 67) begin n_fail++; $display("FAIL b2b_css: first high %0d want 67", css_first); end
    n_checks++;
    if (rxv_n != 2 || rxv_cyc != 65) begin
      n_fail++; $display("FAIL b2b_rxv: %0d pulses last %0d want 2 last 65", rxv_n, rxv_cyc);
    end
    n_checks++; if (rises != 16) begin n_fail++; $display("FAIL b2b_rises: %0d want 16", rises); end
    wait_idle();
  endtask

  task automatic test_flash_gap();
    flash_byte = 8'h3C;
    send(8'h9F, 1'b0);
    repeat (32) tick();
    n_checks++;
    if (rx_data !== 8'h3C || rxv_cyc != 32) begin
      n_fail++; $display("FAIL flash_rx: %h at %0d want 3c at 32", rx_data, rxv_cyc);
    end
    n_checks++;
    if (mosi_cap !== 8'h9F) begin n_fail++; $display("FAIL flash_mosi: %h want 9f", mosi_cap); end
    repeat (12) tick();
    n_checks++;
    if (css_hi != 0 || tx_ready !== 1'b1 || busy !== 1'b1 || s_clk !== 1'b0 || s_mosi !== 1'b1)
    begin
      n_fail++;
      $display("FAIL gap_hold: csshi=%0d rdy=%b busy=%b sclk=%b mosi=%b want 0 1 1 0 1",
               css_hi, tx_ready, busy, s_clk, s_mosi);
    end
    send(8'h00, 1'b1);
    repeat (40) tick();
    n_checks++;
    if (css_first != 34 || rx_data !== 8'h00) begin
      n_fail++; $display("FAIL gap_close: css %0d rx %h want 34 00", css_first, rx_data);
    end
    wait_idle();
  endtask

  task automatic test_ignore_busy();
    flash_byte = 8'hFF;
    tx_valid = 1'b1; tx_data = 8'hA5; tx_last = 1'b1;
    @(posedge p_clk); #1;
    mon_clear();
    for (int k = 1; k <= 34; k++) begin
      tx_data = 8'(k * 37);
      tx_last = 1'b0;
      tick();
    end
    tx_valid = 1'b0;
    n_checks++;
    if (mosi_cap !== 8'hA5) begin n_fail++; $display("FAIL ign_mosi: %h want a5", mosi_cap); end
    n_checks++;
    if (css_first != 34 || rxv_n != 1) begin
      n_fail++; $display("FAIL ign_last: css %0d rxv %0d want 34 1", css_first, rxv_n);
    end
    wait_idle();
  endtask

  task automatic test_reset_mid();
    int n = 0;
    flash_byte = 8'hFF;
    send(8'hC3, 1'b1);
    while (rises < 5 && n < 40) begin tick(); n++; end
    #1 p_reset_n = 1'b0;
    #1;
    n_checks++;
    if (s_css !== 1'b1 || s_clk !== 1'b0 || s_mosi !== 1'b0 || tx_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst: css=%b sclk=%b mosi=%b rdy=%b want 1 0 0 0",
               s_css, s_clk, s_mosi, tx_ready);
    end
    mon_clear();
    repeat (3) tick();
    p_reset_n = 1'b1;
    n = 0;
    while (!tx_ready && n < 10) begin tick(); n++; end
    n_checks++;
    if (rxv_n != 0 || rx_data !== 8'h00) begin
      n_fail++; $display("FAIL mid_rxv: %0d pulses rx %h want 0 00", rxv_n, rx_data);
    end
    n_checks++;
    if (!(tx_ready === 1'b1 && n == 2)) begin
      n_fail++; $display("FAIL mid_ready: %b after %0d want 1 after 2", tx_ready, n);
    end
  endtask

  task automatic test_clkdiv1();
    int         r = 0, vcyc = 0, cfirst = 0;
    logic [7:0] cap = 8'h00;
    logic       pc;
`ifdef SPI_BYTE_SHIFTER_LOOPBACK_EN
    lpbk1 = 1'b1;
`endif
    flash_byte1 = 8'h5A;
    n_checks++;
    if (tx_ready1 !== 1'b1) begin n_fail++; $display("FAIL d1_ready: %b want 1", tx_ready1); end
    tx_valid1 = 1'b1; tx_data1 = 8'h5A; tx_last1 = 1'b1;
    @(posedge p_clk); #1;
    tx_valid1 = 1'b0;
    pc = s_clk1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge p_clk); #1;
      if (s_clk1 && !pc) begin r++; cap = {cap[6:0], s_mosi1}; end
      pc = s_clk1;
      if (rx_valid1) vcyc = c;
      if (s_css1 && cfirst == 0) cfirst = c;
    end
    n_checks++;
    if (cap !== 8'h5A || r != 8) begin
      n_fail++; $display("FAIL d1_mosi: %h in %0d rises want 5a in 8", cap, r);
    end
    n_checks++;
    if (rx_data1 !== 8'h5A || vcyc != 16) begin
      n_fail++; $display("FAIL d1_rx: %h at %0d want 5a at 16", rx_data1, vcyc);
    end
    n_checks++;
    if (cfirst != 17) begin n_fail++; $display("FAIL d1_css: %0d want 17", cfirst); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_a5_last();
    test_back_to_back();
    test_flash_gap();
    test_ignore_busy();
    test_reset_mid();
    test_clkdiv1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_byte_shifter.md
SPI_BYTE_SHIFTER -- requirements
Module: spi_byte_shifter

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 2, meaning SCK half-period in p_clk cycles, legal range 1..255.
REQ-002 The block SHALL have port p_clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-003 The block SHALL have port p_reset_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port tx_valid, input, 1, a byte is offered by the upstream APB controller.
REQ-005 The block SHALL have port tx_data, input, 8, the byte to transmit, MSB first.
REQ-006 The block SHALL have port tx_last, input, 1, release chip select after this byte.
REQ-007 The block SHALL have port tx_ready, output, 1, the block accepts a byte this cycle.
REQ-008 The block SHALL have port rx_valid, output, 1, a one-cycle pulse marking rx_data as updated.
REQ-009 The block SHALL have port rx_data, output, 8, the byte sampled from s_miso.
REQ-010 The block SHALL have port s_clk, output, 1, SPI clock, mode 0 (idles low).
REQ-011 The block SHALL have port s_mosi, output, 1, serial data to the flash.
REQ-012 The block SHALL have port s_miso, input, 1, serial data from the flash.
REQ-013 The block SHALL have port s_css, output, 1, active-low flash chip select.
REQ-014 The block SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-015 The block SHALL implement states DESEL, IDLE, SETUP, SHIFT, GAP and HOLD, plus a half-period counter and a 4-bit edge counter.
REQ-016 tx_ready SHALL be high only in IDLE and GAP; a handshake is tx_valid&&tx_ready, which latches tx_data and tx_last.
REQ-017 Transitions: IDLE or GAP to SETUP on handshake; SETUP to SHIFT after CLK_DIV cycles; SHIFT to GAP (tx_last=0) or HOLD (tx_last=1) after the 16th toggle; HOLD to DESEL after CLK_DIV cycles; DESEL to IDLE after CLK_DIV cycles.
REQ-018 s_css SHALL be 0 in SETUP, SHIFT, GAP and HOLD, and 1 in DESEL and IDLE.
REQ-019 On entry to SETUP, s_mosi SHALL present tx_data[7].
REQ-020 The first s_clk rise SHALL occur CLK_DIV cycles after SETUP entry, then s_clk SHALL toggle every CLK_DIV cycles for 16 toggles in total.
REQ-021 On each s_clk rise, s_miso SHALL be shifted into the receive register LSB-side, so the first sampled bit becomes rx_data[7].
REQ-022 On each of falls 1..7, s_mosi SHALL advance to the next lower bit; after fall 8 it SHALL hold bit0 until reload or deselect.
REQ-023 rx_valid SHALL pulse for exactly one cycle, coincident with the cycle s_clk goes low on fall 8, which is 16*CLK_DIV cycles after the handshake edge; rx_data SHALL update in the same cycle and hold until the next byte completes.
REQ-024 s_clk SHALL be 0 outside SHIFT, and s_mosi SHALL be 0 whenever s_css=1.
REQ-025 In GAP, s_css SHALL stay low indefinitely until the next handshake; back-to-back bytes SHALL keep s_css low continuously.
REQ-026 tx_valid SHALL be ignored while tx_ready=0, and tx_data/tx_last changes outside a handshake SHALL have no effect.
REQ-027 With CLK_DIV=1, s_clk SHALL toggle every p_clk cycle with the same sequencing.

Reset
REQ-028 p_reset_n=0 SHALL immediately, regardless of p_clk, force state=DESEL, s_css=1, s_clk=0, s_mosi=0, rx_valid=0, rx_data=0, counters=0 and tx_ready=0.
REQ-029 After release, the block SHALL spend CLK_DIV cycles in DESEL before IDLE, guaranteeing a minimum deselect time.
REQ-030 Reset asserted mid-byte SHALL abort the transfer with no rx_valid pulse.

Configuration
REQ-031 With macro SPI_BYTE_SHIFTER_LOOPBACK_EN defined, the block SHALL add input port lpbk (1 bit), and when lpbk=1 the rising-edge sampler SHALL take s_mosi instead of s_miso.
REQ-032 Without SPI_BYTE_SHIFTER_LOOPBACK_EN, the lpbk port and mux SHALL be absent, and s_miso SHALL always be sampled.

Verification
REQ-033 CLK_DIV=2, send 0xA5 with tx_last=1 and s_miso tied 1 -> s_mosi bits 1,0,1,0,0,1,0,1 on the rises; rx_data=0xFF; rx_valid 32 cycles after the handshake; s_css high 2 cycles after HOLD.
REQ-034 Send 0x03 (tx_last=0), then 0x00 on the first GAP cycle (tx_last=1) -> s_css low continuously across both bytes; exactly two rx_valid pulses.
REQ-035 Flash model returns 0x3C while 0x9F is sent -> rx_data=0x3C and s_css never toggles mid-byte.
REQ-036 Assert p_reset_n=0 after the 5th s_clk rise -> same-cycle s_css=1, s_clk=0, no rx_valid; tx_ready returns CLK_DIV cycles after release.
REQ-037 CLK_DIV=1 with LOOPBACK_EN and lpbk=1, send 0x5A -> rx_data=0x5A, rx_valid 16 cycles after the handshake.
REQ-038 Hold tx_valid high with a changing tx_data during SHIFT -> only the byte latched at the handshake is transmitted.
